// File: rtl/memory_pkg.sv
// Shared types for the single-port memory abstraction and its read agent.
package memory_pkg;

    // Read latency of the memory being driven.
    typedef enum logic {
        ASYNC_READ = 1'b0,
        SYNC_READ  = 1'b1
    } read_type_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 8;

    // Response payload at default widths; modules with other widths declare
    // a local typedef of the same shape.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } mem_rd_rsp_t;

    // Width of one {addr, data} response entry.
    function automatic int unsigned rsp_width(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/mem_read_rsp_fifo.sv
// Synchronous response FIFO; full/empty from pointers with an extra wrap bit.
module mem_read_rsp_fifo
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr[PTR_W-1:0]];

    // Pointer advance; wraps naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_read_agent.sv
// Read-side initiator: request credit counter, optional one-cycle in-flight
// slot for synchronous memories, and an in-order response FIFO.
// Optional embedded checks: define MEM_READ_AGENT_ASSERT_EN.
module mem_read_agent
    import memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter read_type_t  MEM_TYPE   = ASYNC_READ,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                          rd_clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ADDR_WIDTH-1:0]         rsp_addr,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(RSP_DEPTH):0]    outstanding
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned RSP_W = rsp_width(ADDR_WIDTH, DATA_WIDTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic             accept;
    logic             pop;
    logic             push;
    rsp_t             push_rsp;
    rsp_t             head_rsp;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] outstanding_d;

    assign mem_read_addr = req_addr;
    assign accept        = req_valid && req_ready;
    assign pop           = rsp_valid && rsp_ready;

    generate
        if (MEM_TYPE == SYNC_READ) begin : g_sync
            logic                  slot_valid;
            logic [ADDR_WIDTH-1:0] slot_addr;

            // Hold the accepted address for one cycle while the memory produces data.
            always_ff @(posedge rd_clk) begin
                if (rst) begin
                    slot_valid <= 1'b0;
                    slot_addr  <= '0;
                end else begin
                    slot_valid <= accept;
                    if (accept) slot_addr <= req_addr;
                end
            end

            assign push     = slot_valid;
            assign push_rsp = rsp_t'({slot_addr, mem_read_data});
        end else begin : g_async
            assign push     = accept;
            assign push_rsp = rsp_t'({req_addr, mem_read_data});
        end
    endgenerate

    // Credit count next value: +1 on accept, -1 on pop, unchanged on both.
    always_comb begin
        outstanding_d = outstanding;
        if (accept && !pop) begin
            outstanding_d = outstanding + CNT_W'(1);
        end else if (pop && !accept) begin
            outstanding_d = outstanding - CNT_W'(1);
        end
    end

    // Credit register; req_ready is registered so rsp_ready never reaches it combinationally.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            outstanding <= '0;
            req_ready   <= 1'b1;
        end else begin
            outstanding <= outstanding_d;
            req_ready   <= (outstanding_d < CNT_W'(RSP_DEPTH));
        end
    end

    mem_read_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (rd_clk),
        .rst       (rst),
        .push      (push && !fifo_full),
        .push_data (push_rsp),
        .pop       (pop),
        .head_data (head_rsp),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_addr  = head_rsp.addr;
    assign rsp_data  = head_rsp.data;

`ifdef MEM_READ_AGENT_ASSERT_EN
    default clocking cb @(posedge rd_clk); endclocking

    a_outstanding_max: assert property (disable iff (rst)
        outstanding <= CNT_W'(RSP_DEPTH));
    a_no_push_full: assert property (disable iff (rst)
        push |-> !fifo_full);
    a_no_pop_empty: assert property (disable iff (rst)
        pop |-> !fifo_empty);
    a_rsp_stable: assert property (disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_addr) && $stable(rsp_data)));
    c_queue_full: cover property (disable iff (rst)
        (fifo_count == CNT_W'(RSP_DEPTH)) && !rsp_ready);
`else
    // FIFO occupancy is only consumed by the embedded checks.
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_mem_read_agent.sv
// Bench: one ASYNC_READ and one SYNC_READ agent share stimulus; a queue-based
// model of each (responses become visible after their read latency) is checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_read_agent;
    import memory_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          rsp_ready;
    logic [DW-1:0] mem [256];

    logic          a_req_ready, s_req_ready;
    logic [AW-1:0] a_mem_addr, s_mem_addr;
    logic [DW-1:0] a_mem_data, s_mem_data;
    logic          a_rsp_valid, s_rsp_valid;
    logic [AW-1:0] a_rsp_addr, s_rsp_addr;
    logic [DW-1:0] a_rsp_data, s_rsp_data;
    logic [CW-1:0] a_out, s_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 rd_clk = ~rd_clk;

    // Memory behaviour: combinational read vs one-cycle registered read.
    assign a_mem_data = mem[a_mem_addr];
    always @(posedge rd_clk) s_mem_data <= mem[s_mem_addr];

    mem_read_agent #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_TYPE(ASYNC_READ), .RSP_DEPTH(DEPTH)) dut_a (
        .rd_clk(rd_clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .mem_read_addr(a_mem_addr), .mem_read_data(a_mem_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(a_rsp_addr),
        .rsp_data(a_rsp_data), .outstanding(a_out));

    mem_read_agent #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_TYPE(SYNC_READ), .RSP_DEPTH(DEPTH)) dut_s (
        .rd_clk(rd_clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_addr(req_addr), .mem_read_addr(s_mem_addr), .mem_read_data(s_mem_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(s_rsp_addr),
        .rsp_data(s_rsp_data), .outstanding(s_out));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request is an entry holding the data read
    // at accept time and the cycle from which it may appear on rsp_*.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            vis;
    } ent_t;

    ent_t qa[$];
    ent_t qs[$];
    int   cyc        = 0;
    bit   model_live = 1'b0;

    always @(posedge rd_clk) begin
        bit a_pop, s_pop, a_acc, s_acc;
        if (rst) begin
            qa.delete();
            qs.delete();
            model_live = 1'b1;
            cyc++;
        end else if (model_live) begin
            a_pop = rsp_ready && (qa.size() > 0) && (qa[0].vis <= cyc);
            s_pop = rsp_ready && (qs.size() > 0) && (qs[0].vis <= cyc);
            a_acc = req_valid && (qa.size() < DEPTH);
            s_acc = req_valid && (qs.size() < DEPTH);
            cyc++;
            if (a_pop) void'(qa.pop_front());
            if (s_pop) void'(qs.pop_front());
            if (a_acc) qa.push_back('{addr: req_addr, data: mem[req_addr], vis: cyc});
            if (s_acc) qs.push_back('{addr: req_addr, data: mem[req_addr], vis: cyc + 1});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge rd_clk) begin
        bit ea, es;
        if (model_live) begin
            ea = (qa.size() > 0) && (qa[0].vis <= cyc);
            es = (qs.size() > 0) && (qs[0].vis <= cyc);
            check("a_rsp_valid", 64'(a_rsp_valid), 64'(ea));
            check("s_rsp_valid", 64'(s_rsp_valid), 64'(es));
            check("a_outstanding", 64'(a_out), 64'(qa.size()));
            check("s_outstanding", 64'(s_out), 64'(qs.size()));
            check("a_req_ready", 64'(a_req_ready), 64'(qa.size() < DEPTH));
            check("s_req_ready", 64'(s_req_ready), 64'(qs.size() < DEPTH));
            check("a_mem_read_addr", 64'(a_mem_addr), 64'(req_addr));
            check("s_mem_read_addr", 64'(s_mem_addr), 64'(req_addr));
            if (ea) begin
                check("a_rsp_addr", 64'(a_rsp_addr), 64'(qa[0].addr));
                check("a_rsp_data", 64'(a_rsp_data), 64'(qa[0].data));
            end
            if (es) begin
                check("s_rsp_addr", 64'(s_rsp_addr), 64'(qs[0].addr));
                check("s_rsp_data", 64'(s_rsp_data), 64'(qs[0].data));
            end
        end
    end

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a_seen [4];
        logic [AW-1:0] s_seen [4];
        int a_got, s_got;

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        rst = 1'b1; req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b0;

        // 1: reset held two cycles with a request pending
        step(); step();
        rst = 1'b0; req_valid = 1'b0;
        step();
        check("t1_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("t1_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
        check("t1_a_outstanding", 64'(a_out), 64'd0);
        check("t1_s_outstanding", 64'(s_out), 64'd0);
        check("t1_a_req_ready", 64'(a_req_ready), 64'd1);
        check("t1_s_req_ready", 64'(s_req_ready), 64'd1);

        // 2: single read, data visible on the next cycle for ASYNC
        mem[8'h0a] = 32'hdeadbeef;
        req_addr = 8'h0a; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("t2_a_rsp_valid", 64'(a_rsp_valid), 64'd1);
        check("t2_a_rsp_addr", 64'(a_rsp_addr), 64'h0a);
        check("t2_a_rsp_data", 64'(a_rsp_data), 64'hdeadbeef);
        check("t2_s_rsp_valid_early", 64'(s_rsp_valid), 64'd0);
        step();
        check("t2_s_rsp_data", 64'(s_rsp_data), 64'hdeadbeef);
        idle(3);

        // 3: SYNC back-to-back reads, first response two cycles after accept
        mem[1] = 32'h11111111; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
        req_valid = 1'b1; req_addr = 8'h01;
        step();
        check("t3_s_valid_after_accept", 64'(s_rsp_valid), 64'd0);
        req_addr = 8'h02;
        step();
        check("t3_s_rsp0_addr", 64'(s_rsp_addr), 64'h01);
        check("t3_s_rsp0_data", 64'(s_rsp_data), 64'h11111111);
        req_addr = 8'h03;
        step();
        check("t3_s_rsp1_addr", 64'(s_rsp_addr), 64'h02);
        req_valid = 1'b0;
        step();
        check("t3_s_rsp2_addr", 64'(s_rsp_addr), 64'h03);
        check("t3_s_rsp2_data", 64'(s_rsp_data), 64'h33333333);
        idle(3);

        // 4: five requests under backpressure, only four accepted
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_addr = AW'(8'h20 + i);
            step();
        end
        req_valid = 1'b0;
        check("t4_a_outstanding", 64'(a_out), 64'd4);
        check("t4_s_outstanding", 64'(s_out), 64'd4);
        check("t4_a_req_ready", 64'(a_req_ready), 64'd0);
        check("t4_s_req_ready", 64'(s_req_ready), 64'd0);
        rsp_ready = 1'b1;
        a_got = 0; s_got = 0;
        for (int k = 0; k < 12 && (a_got < 4 || s_got < 4); k++) begin
            if (a_rsp_valid && a_got < 4) begin a_seen[a_got] = a_rsp_addr; a_got++; end
            if (s_rsp_valid && s_got < 4) begin s_seen[s_got] = s_rsp_addr; s_got++; end
            step();
        end
        check("t4_a_rsp_count", 64'(a_got), 64'd4);
        check("t4_s_rsp_count", 64'(s_got), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_got) check("t4_a_order", 64'(a_seen[i]), 64'(8'h20 + i));
            if (i < s_got) check("t4_s_order", 64'(s_seen[i]), 64'(8'h20 + i));
        end
        idle(3);

        // 5: SYNC saturated with 3 queued + 1 in flight, then pop and accept+pop
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'(8'h30 + i);
            step();
        end
        check("t5_s_outstanding_full", 64'(s_out), 64'd4);
        check("t5_s_req_ready_full", 64'(s_req_ready), 64'd0);
        check("t5_s_rsp_valid", 64'(s_rsp_valid), 64'd1);
        req_addr = 8'h34; rsp_ready = 1'b1;
        step();
        check("t5_s_outstanding_pop", 64'(s_out), 64'd3);
        check("t5_s_req_ready_pop", 64'(s_req_ready), 64'd1);
        step();
        check("t5_s_outstanding_acc_pop", 64'(s_out), 64'd3);
        check("t5_s_head_addr", 64'(s_rsp_addr), 64'h32);
        idle(8);

        // 6: reset with three outstanding discards them
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = AW'(8'h40 + i);
            step();
        end
        check("t6_a_outstanding_pre", 64'(a_out), 64'd3);
        check("t6_s_outstanding_pre", 64'(s_out), 64'd3);
        rst = 1'b1; req_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("t6_a_outstanding", 64'(a_out), 64'd0);
        check("t6_s_outstanding", 64'(s_out), 64'd0);
        check("t6_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("t6_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
        req_addr = 8'h0a; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("t6_a_rsp_data", 64'(a_rsp_data), 64'hdeadbeef);
        step();
        check("t6_s_rsp_data", 64'(s_rsp_data), 64'hdeadbeef);
        idle(3);

        // Random traffic with occasional memory updates and resets
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(3) != 0);
            req_addr  = AW'($urandom_range(255));
            rsp_ready = ($urandom_range(2) != 0);
            rst       = ($urandom_range(499) == 0);
            if ($urandom_range(7) == 0) mem[$urandom_range(255)] = $urandom();
            step();
        end
        rst = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
